// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg: state encodings and shared widths for the skid stage
package pipe_skid_reg_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } state_t;
    localparam int DEF_WIDTH = 64;
    localparam int STALL_W = 16;
endpackage

// File: rtl/pipe_skid_reg_dffe_lo.sv
// dffe_lo: WIDTH-bit register with enable and asynchronous active-low clear
module dffe_lo #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge clr)
        if (!clr) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid buffer decoupling in_ready from out_ready
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         occ,
    output logic [STALL_W-1:0] stall_cnt
);
    state_t state, state_nx;
    logic in_xfer, out_xfer, main_en, skid_en;
    logic [WIDTH-1:0] skid, main_d;
    assign out_valid = state != EMPTY;
    assign occ = {state == FULL, state == BUSY};
    assign in_xfer = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign main_d = state == FULL ? skid : in_data;
    always_comb begin
        state_nx = state;
        main_en = 1'b0;
        skid_en = 1'b0;
        case (state)
            EMPTY: begin
                main_en = in_xfer;
                state_nx = in_xfer ? BUSY : EMPTY;
            end
            BUSY: begin
                main_en = in_xfer & out_xfer;
                skid_en = in_xfer & ~out_xfer;
                state_nx = in_xfer ? (out_xfer ? BUSY : FULL) : (out_xfer ? EMPTY : BUSY);
            end
            FULL: begin
                main_en = out_ready;
                state_nx = out_ready ? BUSY : FULL;
            end
            default: state_nx = EMPTY;
        endcase
        // flush discards accepted input and leaves both data registers untouched
        if (flush) begin
            state_nx = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            state <= EMPTY;
            in_ready <= 1'b1;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            in_ready <= state_nx != FULL;
            if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    dffe_lo #(.WIDTH(WIDTH)) u_main (
        .clk(clk),
        .clr(clr),
        .en (main_en),
        .d  (main_d),
        .q  (out_data)
    );
    dffe_lo #(.WIDTH(WIDTH)) u_skid (
        .clk(clk),
        .clr(clr),
        .en (skid_en),
        .d  (in_data),
        .q  (skid)
    );
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter: WIDTH, default 64, payload width in bits (32-bit PC plus 32-bit instruction).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: clr  input  1  reset, asynchronous and active-low.
REQ-004 Port: flush  input  1  synchronous pipeline flush, active-high.
REQ-005 Port: in_valid  input  1  upstream payload valid.
REQ-006 Port: in_ready  output  1  stage can accept; driven directly from a flop.
REQ-007 Port: in_data  input  WIDTH  upstream payload.
REQ-008 Port: out_valid  output  1  downstream payload valid.
REQ-009 Port: out_ready  input  1  downstream accepts.
REQ-010 Port: out_data  output  WIDTH  downstream payload; driven directly from the main register.
REQ-011 Port: occ  output  2  entries held: 0, 1 or 2.
REQ-012 Port: stall_cnt  output  16  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-013 An input transfer SHALL occur when in_valid and in_ready are both 1 at a rising edge. An output transfer SHALL occur when out_valid and out_ready are both 1 at a rising edge.
REQ-014 The state machine SHALL have three states: EMPTY (occ=0), BUSY (main register valid, occ=1) and FULL (main and skid registers valid, occ=2).
REQ-015 EMPTY: an input transfer SHALL load main and go to BUSY; otherwise the block SHALL stay in EMPTY.
REQ-016 BUSY, input and output transfer together: main SHALL load in_data and the state SHALL stay BUSY.
REQ-017 BUSY, output transfer only: the state SHALL go to EMPTY.
REQ-018 BUSY, input transfer only: skid SHALL load in_data and the state SHALL go to FULL.
REQ-019 FULL: on out_ready=1, main SHALL load skid and the state SHALL go to BUSY; no input is accepted in FULL.
REQ-020 in_ready SHALL be 1 in EMPTY and BUSY and 0 in FULL, registered from the next-state value; it SHALL never depend combinationally on out_ready.
REQ-021 out_valid SHALL equal 1 in BUSY and FULL. Latency SHALL be exactly one cycle from an input transfer in EMPTY to out_valid=1.
REQ-022 Payload order SHALL be strictly FIFO; no payload is dropped or duplicated except by flush.
REQ-023 flush=1 SHALL force the next state to EMPTY, set occ=0 and out_valid=0, and set in_ready=1 in the following cycle.
REQ-024 Under flush=1, any same-cycle input transfer SHALL complete toward upstream but its payload SHALL be discarded; any same-cycle output transfer completes normally.
REQ-025 Data registers SHALL keep their contents on flush; out_data is don't-care while out_valid=0.
REQ-026 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, saturate at 16'hFFFF, and be unaffected by flush.

Reset
REQ-027 clr=0 SHALL asynchronously force: state EMPTY, in_ready=1, out_valid=0, out_data=0, skid=0, occ=0, stall_cnt=0.
REQ-028 Reset asserted mid-transfer SHALL discard all held payloads. The first input transfer after clr returns to 1 SHALL behave as from EMPTY.

Structure
REQ-029 A shared package SHALL hold the state encodings (EMPTY=2'b00, BUSY=2'b01, FULL=2'b11), the WIDTH default and the stall_cnt width (16).
REQ-030 The main and skid registers SHALL each be instances of one sub-module, dffe_lo: a WIDTH-bit register with enable and asynchronous active-low clear on clk/clr.

Verification
REQ-031 Reset, then one input 64'hA5A5_0000_0000_0001 with out_ready=1 -> out_valid=1 one cycle later with that out_data, occ=1, then occ=0.
REQ-032 out_ready=0 with three back-to-back inputs 1, 2, 3 -> 1 and 2 accepted, in_ready=0 after the second, occ=2; then out_ready=1 -> outputs 1, 2, 3 in order.
REQ-033 Continuous in_valid=1 and out_ready=1 -> one payload per cycle, occ stays 1, in_ready stays 1.
REQ-034 FULL, then flush=1 with in_valid=1 -> occ=0 and out_valid=0 next cycle; the flushed input never appears at the output.
REQ-035 Hold out_valid=1 with out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF and it stays there.
REQ-036 Assert clr=0 asynchronously between edges while FULL -> all outputs take their reset values immediately, without waiting for a clock edge.
